fpm_norm_round: RTL

Two-stage pipelined normalize/round/pack stage sitting directly downstream of the floating-point multiplier's significand-product array. Accepts sign, both biased exponents and the raw 48-bit significand product over a valid/ready handshake. Produces a packed IEEE-754 single-precision result plus exception flags. Denormal inputs and outputs are flushed to zero.

---
 rtl/fpm_pkg.sv | 45 ++++
 rtl/fpm_round_pack.sv | 56 +++++
 rtl/fpm_norm_round.sv | 86 ++++++++
 3 files changed

// File: rtl/fpm_pkg.sv
// Shared types and constants for the multiplier normalize/round/pack pipeline.
// Class encoding, flag bit positions and the stage-1 to stage-2 beat layout live here.
package fpm_pkg;

  localparam int          FP_BIAS    = 127;
  localparam int          FP_EXP_MAX = 255;
  localparam logic [31:0] FP_QNAN    = 32'h7FC00000;

  localparam int FLG_INVALID = 3;
  localparam int FLG_OVF     = 2;
  localparam int FLG_UNF     = 1;
  localparam int FLG_INX     = 0;

  typedef enum logic [1:0] {
    CLS_NORMAL,
    CLS_ZERO,
    CLS_INF,
    CLS_INVALID
  } fp_class_t;

  // Normalized beat held between stage 1 and stage 2; e is 10-bit two's complement.
  typedef struct packed {
    logic        sign;
    logic [9:0]  e;
    logic [22:0] man;
    logic        guard;
    logic        sticky;
    fp_class_t   cls;
  } s1_t;

  // Exponent-255 operands count as infinity; inf x 0 is the only invalid product.
  function automatic fp_class_t classify(input logic [7:0] ea, input logic [7:0] eb);
    fp_class_t c;
    if ((ea == 8'(FP_EXP_MAX) && eb == 8'h00) || (eb == 8'(FP_EXP_MAX) && ea == 8'h00))
      c = CLS_INVALID;
    else if (ea == 8'(FP_EXP_MAX) || eb == 8'(FP_EXP_MAX))
      c = CLS_INF;
    else if (ea == 8'h00 || eb == 8'h00)
      c = CLS_ZERO;
    else
      c = CLS_NORMAL;
    return c;
  endfunction

endpackage

// File: rtl/fpm_round_pack.sv
// Combinational round, range check and pack of one normalized beat into binary32 plus flags.
// Rounds to nearest-even when FPM_RNE_EN is defined, otherwise truncates; no state, no handshake.
module fpm_round_pack
  import fpm_pkg::*;
(
  input  s1_t         beat,
  output logic [31:0] result,
  output logic [3:0]  flags
);

  logic        rnd_up;
  logic [23:0] man_inc;
  logic [9:0]  e_r;

`ifdef FPM_RNE_EN
  assign rnd_up = beat.guard && (beat.sticky || beat.man[0]);
`else
  assign rnd_up = 1'b0;
`endif

  // A carry out of the 23-bit field leaves man_inc[22:0] at zero and bumps the exponent.
  assign man_inc = {1'b0, beat.man} + {23'b0, rnd_up};
  assign e_r     = beat.e + {9'b0, man_inc[23]};

  always_comb begin
    result = 32'h0;
    flags  = 4'h0;
    unique case (beat.cls)
      CLS_INVALID: begin
        result             = FP_QNAN;
        flags[FLG_INVALID] = 1'b1;
      end
      CLS_INF: begin
        result = {beat.sign, 8'hFF, 23'h0};
      end
      CLS_ZERO: begin
        result = {beat.sign, 31'h0};
      end
      default: begin
        if ($signed(e_r) >= $signed(10'(FP_EXP_MAX))) begin
          result         = {beat.sign, 8'hFF, 23'h0};
          flags[FLG_OVF] = 1'b1;
          flags[FLG_INX] = 1'b1;
        end else if ($signed(e_r) <= $signed(10'd0)) begin
          result         = {beat.sign, 31'h0};
          flags[FLG_UNF] = 1'b1;
          flags[FLG_INX] = 1'b1;
        end else begin
          result         = {beat.sign, e_r[7:0], man_inc[22:0]};
          flags[FLG_INX] = beat.guard | beat.sticky;
        end
      end
    endcase
  end

endmodule

// File: rtl/fpm_norm_round.sv
// Two-stage normalize/round/pack after the 24x24 significand product (FPM_RNE_EN selects RNE).
// Latency 2, 1 beat/cycle; in_ready is combinational from out_ready, output holds while stalled.
module fpm_norm_round
  import fpm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_ea,
  input  logic [7:0]  in_eb,
  input  logic [47:0] in_prod,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [3:0]  out_flags
);

  logic        s1_valid;
  logic        s2_valid;
  logic        s1_adv;
  logic        s2_adv;
  s1_t         s1_nxt;
  s1_t         s1_q;
  logic [31:0] rp_result;
  logic [3:0]  rp_flags;
  logic [9:0]  e_sum;

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // Product of two [1,2) significands lies in [1,4); bit 47 set means one extra binade.
  assign e_sum = {2'b0, in_ea} + {2'b0, in_eb} - 10'(FP_BIAS) + {9'b0, in_prod[47]};

  always_comb begin
    s1_nxt      = '0;
    s1_nxt.sign = in_sign;
    s1_nxt.e    = e_sum;
    s1_nxt.cls  = classify(in_ea, in_eb);
    if (in_prod[47]) begin
      s1_nxt.man    = in_prod[46:24];
      s1_nxt.guard  = in_prod[23];
      s1_nxt.sticky = |in_prod[22:0];
    end else begin
      s1_nxt.man    = in_prod[45:23];
      s1_nxt.guard  = in_prod[22];
      s1_nxt.sticky = |in_prod[21:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid)
        s1_q <= s1_nxt;
    end
  end

  fpm_round_pack u_round_pack (
    .beat   (s1_q),
    .result (rp_result),
    .flags  (rp_flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid   <= 1'b0;
      out_result <= 32'h0;
      out_flags  <= 4'h0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= rp_result;
        out_flags  <= rp_flags;
      end
    end
  end

  assign out_valid = s2_valid;

endmodule
